inst_fetch_axi: RTL and testbench
=================================

INST_FETCH_AXI -- requirements
Module: inst_fetch_axi

Interface
REQ-001 SHALL have parameter ARID_VAL, default 4'd0, giving the constant AXI read ID driven on arid.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port fetch_req  input  1  core requests a fetch of the instruction pair at fetch_pc.
REQ-005 SHALL have port fetch_pc  input  32  byte address of the first instruction of the pair.
REQ-006 SHALL have port fetch_ready  output  1  block accepts fetch_req this cycle.
REQ-007 SHALL have port flush  input  1  discard the in-flight or held pair (branch/jump redirect).
REQ-008 SHALL have port inst_valid  output  1  pair on inst_1/inst_2/inst_pc is valid.
REQ-009 SHALL have port inst_ready  input  1  IF stages consume the pair.
REQ-010 SHALL have port inst_1  output  32  instruction at inst_pc, for pipeline 1.
REQ-011 SHALL have port inst_2  output  32  instruction at inst_pc+4, for pipeline 2.
REQ-012 SHALL have port inst_pc  output  32  address of inst_1.
REQ-013 SHALL have port addr_err  output  1  misaligned fetch_pc detected (only with the macro in REQ-036).
REQ-014 SHALL have port arvalid  output  1  AXI read address valid.
REQ-015 SHALL have port araddr  output  32  AXI read address.
REQ-016 SHALL have port arid  output  4  constant ARID_VAL.
REQ-017 SHALL have port arlen  output  4  constant 4'b0001, a 2-beat burst.
REQ-018 SHALL have port arsize  output  3  constant 3'b010, 4 bytes per beat.
REQ-019 SHALL have port arburst  output  2  constant 2'b01, INCR.
REQ-020 SHALL have port arready  input  1  AXI slave accepts the address.
REQ-021 SHALL have port rvalid  input  1  AXI read data valid.
REQ-022 SHALL have port rdata  input  32  AXI read data beat.
REQ-023 SHALL have port rlast  input  1  last beat of the burst.
REQ-024 SHALL have port rready  output  1  block accepts a read beat.

Function
REQ-025 SHALL implement the FSM IDLE -> ADDR -> BEAT1 -> BEAT2 -> HOLD -> IDLE, with one fetch outstanding at a time.
REQ-026 SHALL assert fetch_ready only in IDLE; on fetch_req & fetch_ready it SHALL latch fetch_pc into araddr/inst_pc, assert arvalid next cycle, and enter ADDR.
REQ-027 SHALL hold arvalid and araddr stable in ADDR until arvalid & arready; it SHALL then deassert arvalid in the following cycle and enter BEAT1.
REQ-028 SHALL assert rready in BEAT1/BEAT2 only; a beat SHALL be taken on rvalid & rready, the first beat into inst_1 and the second into inst_2.
REQ-029 SHALL enter HOLD on the second beat, in which rlast is required; if rlast arrives on the first beat, inst_2 SHALL be 32'h0 and HOLD is still entered.
REQ-030 SHALL assert inst_valid in HOLD, holding the data stable until inst_ready, then return to IDLE; minimum latency is fetch accept to inst_valid = 4 cycles with zero-wait arready/rvalid.
REQ-031 On flush in ADDR, BEAT1 or BEAT2, SHALL finish the AXI transaction (the address handshake and both beats, without dropping arvalid) and discard its data, then return to IDLE without inst_valid.
REQ-032 On flush in HOLD, SHALL drop inst_valid next cycle and go to IDLE; flush in IDLE is a no-op, and a simultaneous fetch_req is ignored.
REQ-033 On simultaneous flush and inst_ready in HOLD, flush SHALL win, and the pair SHALL be counted as not consumed.

Reset
REQ-034 While reset is low, SHALL asynchronously force state IDLE and arvalid, rready, inst_valid, addr_err, araddr, inst_1, inst_2 and inst_pc all to 0; fetch_ready SHALL be 1 on the first cycle after release.
REQ-035 Reset asserted mid-burst SHALL abandon the transaction; beats arriving after release while in IDLE SHALL be ignored, with rready at 0.

Configuration
REQ-036 With IFETCH_ALIGN_CHECK_EN defined, an accepted fetch_pc with [1:0] != 0 SHALL issue no AXI request and SHALL go to HOLD with addr_err=1, inst_1=inst_2=0 and inst_pc=fetch_pc.
REQ-037 Without IFETCH_ALIGN_CHECK_EN, addr_err SHALL be tied to 0, and araddr SHALL be {fetch_pc[31:2],2'b00}.

Verification
REQ-038 Zero-wait slave with fetch_pc=32'hBFC00000 -> araddr=BFC00000, arlen=1; beats 3C080001 and 25080002 -> inst_1=3C080001, inst_2=25080002, inst_valid at cycle 4.
REQ-039 arready delayed 3 cycles -> arvalid held high with araddr unchanged for 4 cycles, then low.
REQ-040 flush asserted in BEAT1 -> both beats accepted, inst_valid never set, fetch_ready=1 the cycle after the second beat.
REQ-041 inst_ready held low 5 cycles in HOLD -> inst_1, inst_2 and inst_pc stable, and no new arvalid.
REQ-042 reset low during BEAT2 -> all outputs 0 at once; after release, fetch 32'hBFC00008 completes normally.
REQ-043 With IFETCH_ALIGN_CHECK_EN, fetch_pc=32'hBFC00002 -> no arvalid, addr_err=1, inst_valid=1.

Source files
------------

// File: rtl/inst_fetch_axi.sv
// -----------------------------------------------------------------------------
// inst_fetch_axi
//
// Instruction-pair fetch unit. It fetches two consecutive 32-bit instructions
// (pc and pc+4) over an AXI read channel as a single 2-beat INCR burst and
// presents them to the dual-issue IF stages. Only one fetch is outstanding at
// any time.
//
// Sequence: IDLE -> ADDR -> BEAT1 -> BEAT2 -> HOLD -> IDLE.
// A flush while the burst is in flight lets the AXI transaction complete so
// that no beats are orphaned on the bus. The returned data is then dropped.
//
// Optional feature: define IFETCH_ALIGN_CHECK_EN to trap misaligned fetch_pc.
// A misaligned fetch then goes straight to HOLD with addr_err=1 and issues no
// bus request. Without the macro, addr_err is tied to 0 and the address is
// word-aligned on the bus.
//
// Ports
//   clk, reset             clock and asynchronous active-low reset
//   fetch_req/fetch_pc     fetch request from the core; fetch_ready = accept
//   flush                  redirect: discard the in-flight or held pair
//   inst_valid/inst_ready  pair handshake towards the IF stages
//   inst_1/inst_2/inst_pc  instruction pair and the address of inst_1
//   addr_err               misaligned fetch flag (align-check build only)
//   ar*/r*                 AXI read address and read data channels
// -----------------------------------------------------------------------------
module inst_fetch_axi #(
    parameter logic [3:0] ARID_VAL = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    output logic        fetch_ready,
    input  logic        flush,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_1,
    output logic [31:0] inst_2,
    output logic [31:0] inst_pc,
    output logic        addr_err,
    output logic        arvalid,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        arready,
    input  logic        rvalid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    output logic        rready
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_BEAT1 = 3'd2,
        ST_BEAT2 = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    state_e      state_r;
    state_e      state_nxt_s;
    logic        discard_r;
    logic        discard_nxt_s;
    logic        fetch_ready_r;
    logic        arvalid_r;
    logic        rready_r;
    logic        inst_valid_r;
    logic        addr_err_r;
    logic        addr_err_nxt_s;
    logic [31:0] araddr_r;
    logic [31:0] araddr_nxt_s;
    logic [31:0] inst_1_r;
    logic [31:0] inst_1_nxt_s;
    logic [31:0] inst_2_r;
    logic [31:0] inst_2_nxt_s;
    logic [31:0] inst_pc_r;
    logic [31:0] inst_pc_nxt_s;
    logic        beat_s;

    assign beat_s = rvalid & rready_r;

    // Next-state and next-data decode for the fetch sequence.
    always_comb begin
        state_nxt_s    = state_r;
        discard_nxt_s  = discard_r;
        addr_err_nxt_s = addr_err_r;
        araddr_nxt_s   = araddr_r;
        inst_1_nxt_s   = inst_1_r;
        inst_2_nxt_s   = inst_2_r;
        inst_pc_nxt_s  = inst_pc_r;
        case (state_r)
            ST_IDLE: begin
                discard_nxt_s = 1'b0;
                // A flush in IDLE takes precedence over a same-cycle request.
                if (fetch_req && !flush) begin
                    inst_pc_nxt_s = fetch_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
                    if (fetch_pc[1:0] != 2'b00) begin
                        state_nxt_s    = ST_HOLD;
                        addr_err_nxt_s = 1'b1;
                        inst_1_nxt_s   = 32'h0000_0000;
                        inst_2_nxt_s   = 32'h0000_0000;
                    end else begin
                        state_nxt_s  = ST_ADDR;
                        araddr_nxt_s = {fetch_pc[31:2], 2'b00};
                    end
`else
                    state_nxt_s  = ST_ADDR;
                    araddr_nxt_s = {fetch_pc[31:2], 2'b00};
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (flush) begin
                    discard_nxt_s = 1'b1;
                end else begin
                    discard_nxt_s = discard_r;
                end
                if (arvalid_r && arready) begin
                    state_nxt_s = ST_BEAT1;
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_BEAT1: begin
                if (flush) begin
                    discard_nxt_s = 1'b1;
                end else begin
                    discard_nxt_s = discard_r;
                end
                if (beat_s) begin
                    inst_1_nxt_s = rdata;
                    if (rlast) begin
                        // Slave ended the burst early: no second instruction.
                        inst_2_nxt_s = 32'h0000_0000;
                        state_nxt_s  = (discard_r || flush) ? ST_IDLE : ST_HOLD;
                    end else begin
                        state_nxt_s = ST_BEAT2;
                    end
                end else begin
                    state_nxt_s = ST_BEAT1;
                end
            end
            ST_BEAT2: begin
                if (flush) begin
                    discard_nxt_s = 1'b1;
                end else begin
                    discard_nxt_s = discard_r;
                end
                if (beat_s) begin
                    inst_2_nxt_s = rdata;
                    state_nxt_s  = (discard_r || flush) ? ST_IDLE : ST_HOLD;
                end else begin
                    state_nxt_s = ST_BEAT2;
                end
            end
            ST_HOLD: begin
                // Flush and consume both leave HOLD; flush means the pair is
                // treated as not consumed, which needs no extra action here.
                if (flush || inst_ready) begin
                    state_nxt_s    = ST_IDLE;
                    addr_err_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                discard_nxt_s = 1'b0;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            discard_r     <= 1'b0;
            fetch_ready_r <= 1'b1;
            arvalid_r     <= 1'b0;
            rready_r      <= 1'b0;
            inst_valid_r  <= 1'b0;
            addr_err_r    <= 1'b0;
            araddr_r      <= 32'h0000_0000;
            inst_1_r      <= 32'h0000_0000;
            inst_2_r      <= 32'h0000_0000;
            inst_pc_r     <= 32'h0000_0000;
        end else begin
            state_r       <= state_nxt_s;
            discard_r     <= discard_nxt_s;
            fetch_ready_r <= (state_nxt_s == ST_IDLE);
            arvalid_r     <= (state_nxt_s == ST_ADDR);
            rready_r      <= (state_nxt_s == ST_BEAT1) || (state_nxt_s == ST_BEAT2);
            inst_valid_r  <= (state_nxt_s == ST_HOLD);
            addr_err_r    <= addr_err_nxt_s;
            araddr_r      <= araddr_nxt_s;
            inst_1_r      <= inst_1_nxt_s;
            inst_2_r      <= inst_2_nxt_s;
            inst_pc_r     <= inst_pc_nxt_s;
        end
    end

    assign fetch_ready = fetch_ready_r;
    assign arvalid     = arvalid_r;
    assign rready      = rready_r;
    assign inst_valid  = inst_valid_r;
    assign araddr      = araddr_r;
    assign inst_1      = inst_1_r;
    assign inst_2      = inst_2_r;
    assign inst_pc     = inst_pc_r;
`ifdef IFETCH_ALIGN_CHECK_EN
    assign addr_err    = addr_err_r;
`else
    assign addr_err    = 1'b0;
`endif

    assign arid    = ARID_VAL;
    assign arlen   = 4'b0001;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

endmodule

// File: tb/tb_inst_fetch_axi.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_axi
//
// Self-checking bench for inst_fetch_axi. The bench plays the core, the IF
// stages and an AXI slave with randomized wait states. Each fetch is a
// transaction whose expected bus address, returned pair and pass/discard
// outcome follow from the fetch rules (aligned address, beat order, early
// rlast, flush windows).
// -----------------------------------------------------------------------------
module tb_inst_fetch_axi;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        flush;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_1;
    logic [31:0] inst_2;
    logic [31:0] inst_pc;
    logic        addr_err;
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
    logic        rready;

    int n_tests;
    int n_fail;

    inst_fetch_axi #(.ARID_VAL(4'd5)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .flush       (flush),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_1      (inst_1),
        .inst_2      (inst_2),
        .inst_pc     (inst_pc),
        .addr_err    (addr_err),
        .arvalid     (arvalid),
        .araddr      (araddr),
        .arid        (arid),
        .arlen       (arlen),
        .arsize      (arsize),
        .arburst     (arburst),
        .arready     (arready),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .rlast       (rlast),
        .rready      (rready)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the run ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Wait (bounded) until the block is ready for a new fetch.
    task automatic wait_idle();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fetch_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wait_idle", {31'd0, seen}, 32'd1);
    endtask

    // One complete fetch transaction with an AXI slave model.
    // flush_at: 0 none, 1 in ADDR, 2 in BEAT1, 3 in HOLD (with inst_ready).
    task automatic do_fetch(input logic [31:0] pc, input int ar_wait, input int r_wait,
                            input bit early, input int flush_at, input int hold_wait,
                            input logic [31:0] d1, input logic [31:0] d2);
        logic [31:0] a_exp;
        logic [31:0] i2_exp;
        bit          discard;
        int          nbeats;
        a_exp   = {pc[31:2], 2'b00};
        i2_exp  = early ? 32'h0 : d2;
        discard = (flush_at == 1) || (flush_at == 2);
        nbeats  = early ? 1 : 2;
        wait_idle();
        fetch_req = 1'b1;
        fetch_pc  = pc;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        fetch_pc  = $urandom;
        for (int i = 0; i <= ar_wait; i++) begin
            arready = (i == ar_wait);
            flush   = (flush_at == 1) && (i == 0);
            @(negedge clk);
            chk("arvalid_addr", {31'd0, arvalid}, 32'd1);
            chk("araddr", araddr, a_exp);
            chk("rready_addr", {31'd0, rready}, 32'd0);
            chk("fetch_ready_busy", {31'd0, fetch_ready}, 32'd0);
            @(posedge clk); #1;
        end
        arready = 1'b0;
        flush   = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            for (int i = 0; i <= r_wait; i++) begin
                rvalid = (i == r_wait);
                rdata  = (i == r_wait) ? ((b == 0) ? d1 : d2) : $urandom;
                rlast  = (i == r_wait) && (early || (b == 1));
                flush  = (flush_at == 2) && (b == 0) && (i == 0);
                @(negedge clk);
                chk("arvalid_beat", {31'd0, arvalid}, 32'd0);
                chk("rready_beat", {31'd0, rready}, 32'd1);
                chk("inst_valid_beat", {31'd0, inst_valid}, 32'd0);
                @(posedge clk); #1;
            end
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        flush  = 1'b0;
        @(negedge clk);
        if (discard) begin
            chk("inst_valid_flushed", {31'd0, inst_valid}, 32'd0);
            chk("fetch_ready_flushed", {31'd0, fetch_ready}, 32'd1);
            chk("rready_flushed", {31'd0, rready}, 32'd0);
        end else begin
            for (int h = 0; h <= hold_wait; h++) begin
                chk("inst_valid_hold", {31'd0, inst_valid}, 32'd1);
                chk("inst_1", inst_1, d1);
                chk("inst_2", inst_2, i2_exp);
                chk("inst_pc", inst_pc, pc);
                chk("arvalid_hold", {31'd0, arvalid}, 32'd0);
                chk("rready_hold", {31'd0, rready}, 32'd0);
                chk("fetch_ready_hold", {31'd0, fetch_ready}, 32'd0);
                chk("addr_err_hold", {31'd0, addr_err}, 32'd0);
                // A request while holding must not start a new burst.
                fetch_req  = (h < hold_wait);
                fetch_pc   = $urandom;
                inst_ready = (h == hold_wait);
                flush      = (h == hold_wait) && (flush_at == 3);
                @(posedge clk); #1;
                fetch_req  = 1'b0;
                inst_ready = 1'b0;
                flush      = 1'b0;
                @(negedge clk);
            end
            chk("inst_valid_done", {31'd0, inst_valid}, 32'd0);
            chk("fetch_ready_done", {31'd0, fetch_ready}, 32'd1);
            chk("arvalid_done", {31'd0, arvalid}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] rnd;
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b0;
        fetch_req  = 1'b0;
        fetch_pc   = 32'h0;
        flush      = 1'b0;
        inst_ready = 1'b0;
        arready    = 1'b0;
        rvalid     = 1'b0;
        rdata      = 32'h0;
        rlast      = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_rready", {31'd0, rready}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_fetch_ready", {31'd0, fetch_ready}, 32'd1);
        chk("arid", {28'd0, arid}, 32'd5);
        chk("arlen", {28'd0, arlen}, 32'd1);
        chk("arsize", {29'd0, arsize}, 32'd2);
        chk("arburst", {30'd0, arburst}, 32'd1);

        // Zero-wait reference fetch: inst_valid in the 4th cycle after the request.
        do_fetch(32'hBFC0_0000, 0, 0, 1'b0, 0, 0, 32'h3C08_0001, 32'h2508_0002);
        // arready delayed 3 cycles.
        do_fetch(32'hBFC0_0010, 3, 0, 1'b0, 0, 0, $urandom, $urandom);
        // Flush in BEAT1: both beats taken, no inst_valid.
        do_fetch(32'hBFC0_0020, 0, 1, 1'b0, 2, 0, $urandom, $urandom);
        // Flush in ADDR.
        do_fetch(32'hBFC0_0030, 2, 0, 1'b0, 1, 0, $urandom, $urandom);
        // inst_ready held low 5 cycles in HOLD.
        do_fetch(32'hBFC0_0040, 0, 0, 1'b0, 0, 5, $urandom, $urandom);
        // rlast on the first beat.
        do_fetch(32'hBFC0_0050, 1, 2, 1'b1, 0, 1, $urandom, $urandom);
        // Flush with inst_ready in HOLD.
        do_fetch(32'hBFC0_0060, 0, 0, 1'b0, 3, 2, $urandom, $urandom);

        // Flush in IDLE blocks a simultaneous request.
        wait_idle();
        flush     = 1'b1;
        fetch_req = 1'b1;
        fetch_pc  = 32'hBFC0_0070;
        @(posedge clk); #1;
        flush     = 1'b0;
        fetch_req = 1'b0;
        @(negedge clk);
        chk("idle_flush_arvalid", {31'd0, arvalid}, 32'd0);
        chk("idle_flush_ready", {31'd0, fetch_ready}, 32'd1);

        // Misaligned fetch address.
`ifdef IFETCH_ALIGN_CHECK_EN
        wait_idle();
        fetch_req = 1'b1;
        fetch_pc  = 32'hBFC0_0002;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        @(negedge clk);
        chk("mis_arvalid", {31'd0, arvalid}, 32'd0);
        chk("mis_addr_err", {31'd0, addr_err}, 32'd1);
        chk("mis_inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("mis_inst_1", inst_1, 32'h0);
        chk("mis_inst_2", inst_2, 32'h0);
        chk("mis_inst_pc", inst_pc, 32'hBFC0_0002);
        inst_ready = 1'b1;
        @(posedge clk); #1;
        inst_ready = 1'b0;
        @(negedge clk);
        chk("mis_done_valid", {31'd0, inst_valid}, 32'd0);
        chk("mis_done_err", {31'd0, addr_err}, 32'd0);
`else
        do_fetch(32'hBFC0_0002, 1, 0, 1'b0, 0, 0, $urandom, $urandom);
`endif

        // Reset during BEAT2.
        wait_idle();
        fetch_req = 1'b1;
        fetch_pc  = 32'hBFC0_0080;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        arready   = 1'b1;
        @(posedge clk); #1;
        arready   = 1'b0;
        rvalid    = 1'b1;
        rdata     = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rvalid    = 1'b0;
        chk("pre_rst_rready", {31'd0, rready}, 32'd1);
        chk("pre_rst_inst_1", inst_1, 32'hDEAD_BEEF);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_rready", {31'd0, rready}, 32'd0);
        chk("arst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("arst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("arst_addr_err", {31'd0, addr_err}, 32'd0);
        chk("arst_araddr", araddr, 32'h0);
        chk("arst_inst_1", inst_1, 32'h0);
        chk("arst_inst_2", inst_2, 32'h0);
        chk("arst_inst_pc", inst_pc, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        // Stray beats after release are ignored.
        rvalid = 1'b1;
        rlast  = 1'b1;
        rdata  = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stray_rready", {31'd0, rready}, 32'd0);
            chk("stray_fetch_ready", {31'd0, fetch_ready}, 32'd1);
            chk("stray_inst_valid", {31'd0, inst_valid}, 32'd0);
        end
        @(posedge clk); #1;
        rvalid = 1'b0;
        rlast  = 1'b0;
        do_fetch(32'hBFC0_0008, 0, 0, 1'b0, 0, 0, $urandom, $urandom);

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            rnd = $urandom;
            do_fetch({rnd[31:2], 2'b00}, $urandom_range(0, 3), $urandom_range(0, 2),
                     ($urandom_range(0, 4) == 0), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
